// File: rtl/cordic_elastic_pipe_pkg.sv
// Shared types for the CORDIC elastic pipe: skid stage state and payload width helper.
// Pure declarations; no timing, no flow control.
package cordic_pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  // Payload is {x, y, z, mode, sign}.
  function automatic int pipe_payload_w(input int width);
    return 3 * width + 2;
  endfunction

endpackage

// File: rtl/cordic_elastic_pipe_if.sv
// Beat bus of the CORDIC elastic pipe: upstream operands in, head beat out, flush and occupancy.
// slave faces the pipe, master faces the block driving and consuming it.
interface cordic_elastic_pipe_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1
);
  localparam int CW = $clog2(2 * DEPTH + 1);

  logic signed [WIDTH-1:0] i_x;
  logic signed [WIDTH-1:0] i_y;
  logic signed [WIDTH-1:0] i_z;
  logic                    i_mode;
  logic                    i_sign;
  logic                    valid_in;
  logic                    ready_out;
  logic signed [WIDTH-1:0] o_x;
  logic signed [WIDTH-1:0] o_y;
  logic signed [WIDTH-1:0] o_z;
  logic                    o_mode;
  logic                    o_sign;
  logic                    valid_out;
  logic                    ready_in;
  logic                    flush;
  logic [CW-1:0]           o_count;

  modport slave (
    input  i_x, i_y, i_z, i_mode, i_sign, valid_in, ready_in, flush,
    output ready_out, o_x, o_y, o_z, o_mode, o_sign, valid_out, o_count
  );

  modport master (
    output i_x, i_y, i_z, i_mode, i_sign, valid_in, ready_in, flush,
    input  ready_out, o_x, o_y, o_z, o_mode, o_sign, valid_out, o_count
  );

endinterface

// File: rtl/cordic_skid_stage.sv
// One skid stage on a flat payload: 1-cycle latency, 2-beat capacity.
// ready_out/valid_out are flops, so ready_in never reaches ready_out combinationally.
module cordic_skid_stage
  import cordic_pipe_pkg::*;
#(
  parameter int PW = 50
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          valid_in,
  output logic          ready_out,
  input  logic [PW-1:0] data_in,
  output logic          valid_out,
  input  logic          ready_in,
  output logic [PW-1:0] data_out,
  output logic [1:0]    o_fill
);

  skid_state_t   r_state;
  logic [PW-1:0] r_main;
  logic [PW-1:0] r_skid;
  logic          r_vld;
  logic          r_rdy;
  logic [1:0]    r_fill;
  logic          w_acc;
  logic          w_tk;

  assign w_acc = valid_in & r_rdy;
  assign w_tk  = r_vld & ready_in;

  // Flush clears occupancy only; data registers keep their contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
      r_vld   <= 1'b0;
      r_rdy   <= 1'b1;
      r_fill  <= 2'd0;
    end else if (flush) begin
      r_state <= EMPTY;
      r_vld   <= 1'b0;
      r_rdy   <= 1'b1;
      r_fill  <= 2'd0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_acc) begin
            r_main  <= data_in;
            r_state <= HALF;
            r_vld   <= 1'b1;
            r_fill  <= 2'd1;
          end
        end
        HALF: begin
          if (w_acc && !w_tk) begin
            r_skid  <= data_in;
            r_state <= FULL;
            r_rdy   <= 1'b0;
            r_fill  <= 2'd2;
          end else if (!w_acc && w_tk) begin
            r_state <= EMPTY;
            r_vld   <= 1'b0;
            r_fill  <= 2'd0;
          end else if (w_acc && w_tk) begin
            r_main <= data_in;
          end
        end
        FULL: begin
          if (w_tk) begin
            r_main  <= r_skid;
            r_state <= HALF;
            r_rdy   <= 1'b1;
            r_fill  <= 2'd1;
          end
        end
        default: begin
          r_state <= EMPTY;
          r_vld   <= 1'b0;
          r_rdy   <= 1'b1;
          r_fill  <= 2'd0;
        end
      endcase
    end
  end

  assign ready_out = r_rdy;
  assign valid_out = r_vld;
  assign data_out  = r_main;
  assign o_fill    = r_fill;

endmodule

// File: rtl/cordic_elastic_pipe.sv
// DEPTH chained skid stages carrying the CORDIC beat: DEPTH-cycle latency at full rate, 2*DEPTH capacity.
// Stalls absorb into skid registers; ready_out falls only when stage 0 is FULL.
module cordic_elastic_pipe
  import cordic_pipe_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cordic_elastic_pipe_if.slave  bus
);

  localparam int PW = pipe_payload_w(WIDTH);
  localparam int CW = $clog2(2 * DEPTH + 1);

  logic [PW-1:0] w_dat  [DEPTH+1];
  logic          w_vld  [DEPTH+1];
  logic          w_rdy  [DEPTH+1];
  logic [1:0]    w_fill [DEPTH];
  logic [CW-1:0] w_count;

  assign w_dat[0]     = {bus.i_x, bus.i_y, bus.i_z, bus.i_mode, bus.i_sign};
  assign w_vld[0]     = bus.valid_in;
  assign bus.ready_out = w_rdy[0];
  assign w_rdy[DEPTH] = bus.ready_in;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    cordic_skid_stage #(.PW(PW)) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (bus.flush),
      .valid_in  (w_vld[k]),
      .ready_out (w_rdy[k]),
      .data_in   (w_dat[k]),
      .valid_out (w_vld[k+1]),
      .ready_in  (w_rdy[k+1]),
      .data_out  (w_dat[k+1]),
      .o_fill    (w_fill[k])
    );
  end

  // Sum of per-stage fill flops; no input reaches the count combinationally.
  always_comb begin
    w_count = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_count = w_count + CW'(w_fill[k]);
    end
  end

  assign bus.valid_out = w_vld[DEPTH];
  assign bus.o_x       = w_dat[DEPTH][PW-1 -: WIDTH];
  assign bus.o_y       = w_dat[DEPTH][2*WIDTH+1 -: WIDTH];
  assign bus.o_z       = w_dat[DEPTH][WIDTH+1 -: WIDTH];
  assign bus.o_mode    = w_dat[DEPTH][1];
  assign bus.o_sign    = w_dat[DEPTH][0];
  assign bus.o_count   = w_count;

endmodule

// File: tb/tb_cordic_elastic_pipe.sv
// Directed bench for cordic_elastic_pipe: three instances (D3/W16, D2/W16, D4/W32).
module tb_cordic_elastic_pipe;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  cordic_elastic_pipe_if #(.WIDTH(16), .DEPTH(3)) if_d3 ();
  cordic_elastic_pipe_if #(.WIDTH(16), .DEPTH(2)) if_d2 ();
  cordic_elastic_pipe_if #(.WIDTH(32), .DEPTH(4)) if_d4 ();

  cordic_elastic_pipe #(.WIDTH(16), .DEPTH(3)) u_d3 (.clk(clk), .rst_n(rst_n), .bus(if_d3.slave));
  cordic_elastic_pipe #(.WIDTH(16), .DEPTH(2)) u_d2 (.clk(clk), .rst_n(rst_n), .bus(if_d2.slave));
  cordic_elastic_pipe #(.WIDTH(32), .DEPTH(4)) u_d4 (.clk(clk), .rst_n(rst_n), .bus(if_d4.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Beat k: x=k, y=-k, z=2k, mode=k[0], sign=~k[0].
  function automatic logic [49:0] beat16(input int k);
    logic [15:0] x;
    x = 16'(k);
    return {x, 16'(-k), 16'(2 * k), x[0], ~x[0]};
  endfunction

  task automatic drive_d3(input int k);
    {if_d3.i_x, if_d3.i_y, if_d3.i_z, if_d3.i_mode, if_d3.i_sign} = beat16(k);
  endtask

  task automatic drive_d2(input int k);
    {if_d2.i_x, if_d2.i_y, if_d2.i_z, if_d2.i_mode, if_d2.i_sign} = beat16(k);
  endtask

  task automatic idle_all();
    if_d3.valid_in = 0; if_d3.ready_in = 0; if_d3.flush = 0; drive_d3(0);
    if_d2.valid_in = 0; if_d2.ready_in = 0; if_d2.flush = 0; drive_d2(0);
    if_d4.valid_in = 0; if_d4.ready_in = 0; if_d4.flush = 0;
    {if_d4.i_x, if_d4.i_y, if_d4.i_z, if_d4.i_mode, if_d4.i_sign} = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (if_d3.valid_out !== 1'b0) begin n_err++; $display("FAIL reset_valid_d3 got %b want 0", if_d3.valid_out); end
    n_cmp++; if (if_d3.ready_out !== 1'b1) begin n_err++; $display("FAIL reset_ready_d3 got %b want 1", if_d3.ready_out); end
    n_cmp++; if (if_d3.o_count !== 3'd0) begin n_err++; $display("FAIL reset_count_d3 got %0d want 0", if_d3.o_count); end
    n_cmp++; if ({if_d3.o_x, if_d3.o_y, if_d3.o_z, if_d3.o_mode, if_d3.o_sign} !== 50'd0) begin
      n_err++; $display("FAIL reset_payload_d3 got %h want 0", {if_d3.o_x, if_d3.o_y, if_d3.o_z, if_d3.o_mode, if_d3.o_sign}); end
    n_cmp++; if (if_d2.ready_out !== 1'b1 || if_d2.valid_out !== 1'b0) begin
      n_err++; $display("FAIL reset_hs_d2 got rdy=%b vld=%b want rdy=1 vld=0", if_d2.ready_out, if_d2.valid_out); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_streaming();
    int got   = 0;
    int first = -1;
    logic [49:0] act;
    if_d3.ready_in = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (c < 10) begin if_d3.valid_in = 1'b1; drive_d3(c + 1); end
      else if_d3.valid_in = 1'b0;
      @(negedge clk);
      n_cmp++; if (if_d3.ready_out !== 1'b1) begin n_err++; $display("FAIL stream_ready c=%0d got %b want 1", c, if_d3.ready_out); end
      if (if_d3.valid_out === 1'b1) begin
        if (first < 0) first = c;
        act = {if_d3.o_x, if_d3.o_y, if_d3.o_z, if_d3.o_mode, if_d3.o_sign};
        n_cmp++; if (act !== beat16(got + 1)) begin n_err++; $display("FAIL stream_data #%0d got %h want %h", got + 1, act, beat16(got + 1)); end
        got++;
      end else if (got > 0 && got < 10) begin
        n_cmp++; n_err++; $display("FAIL stream_gap c=%0d got valid 0 want 1", c);
      end
    end
    n_cmp++; if (first != 3) begin n_err++; $display("FAIL stream_latency got %0d want 3", first); end
    n_cmp++; if (got != 10) begin n_err++; $display("FAIL stream_count got %0d want 10", got); end
    if_d3.ready_in = 1'b0;
  endtask

  task automatic test_backpressure();
    int next = 1;
    int acc  = 0;
    int got  = 0;
    logic [49:0] act;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if_d2.ready_in = (c >= 8);
      if (next <= 6) begin if_d2.valid_in = 1'b1; drive_d2(next); end
      else if_d2.valid_in = 1'b0;
      @(negedge clk);
      if (c == 7) begin
        n_cmp++; if (acc != 4) begin n_err++; $display("FAIL bp_accepts got %0d want 4", acc); end
        n_cmp++; if (if_d2.ready_out !== 1'b0) begin n_err++; $display("FAIL bp_ready got %b want 0", if_d2.ready_out); end
        n_cmp++; if (if_d2.o_count !== 3'd4) begin n_err++; $display("FAIL bp_count got %0d want 4", if_d2.o_count); end
      end
      if (if_d2.valid_in && if_d2.ready_out) begin acc++; next++; end
      if (if_d2.valid_out && if_d2.ready_in) begin
        act = {if_d2.o_x, if_d2.o_y, if_d2.o_z, if_d2.o_mode, if_d2.o_sign};
        n_cmp++; if (act !== beat16(got + 1)) begin n_err++; $display("FAIL bp_data #%0d got %h want %h", got + 1, act, beat16(got + 1)); end
        got++;
      end
    end
    n_cmp++; if (got != 6) begin n_err++; $display("FAIL bp_drained got %0d want 6", got); end
    if_d2.valid_in = 1'b0;
    if_d2.ready_in = 1'b0;
  endtask

  task automatic test_flush();
    int got = 0;
    logic [49:0] act;
    if_d2.ready_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if_d2.valid_in = 1'b1; drive_d2(c + 1);
      @(negedge clk);
      n_cmp++; if (if_d2.ready_out !== 1'b1) begin n_err++; $display("FAIL flush_fill_ready c=%0d got %b want 1", c, if_d2.ready_out); end
    end
    @(posedge clk); #1;
    drive_d2(16'h7FFF);
    if_d2.valid_in = 1'b1;
    if_d2.flush    = 1'b1;
    @(negedge clk);
    n_cmp++; if (if_d2.o_count !== 3'd3) begin n_err++; $display("FAIL flush_pre_count got %0d want 3", if_d2.o_count); end
    @(posedge clk); #1;
    if_d2.flush = 1'b0; if_d2.valid_in = 1'b0; if_d2.ready_in = 1'b1;
    @(negedge clk);
    n_cmp++; if (if_d2.valid_out !== 1'b0) begin n_err++; $display("FAIL flush_valid got %b want 0", if_d2.valid_out); end
    n_cmp++; if (if_d2.o_count !== 3'd0) begin n_err++; $display("FAIL flush_count got %0d want 0", if_d2.o_count); end
    n_cmp++; if (if_d2.ready_out !== 1'b1) begin n_err++; $display("FAIL flush_ready got %b want 1", if_d2.ready_out); end
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if_d2.valid_in = (c == 0);
      drive_d2(16'h0055);
      @(negedge clk);
      if (if_d2.valid_out === 1'b1) begin
        act = {if_d2.o_x, if_d2.o_y, if_d2.o_z, if_d2.o_mode, if_d2.o_sign};
        n_cmp++; if (act !== beat16(16'h0055)) begin n_err++; $display("FAIL flush_leak got %h want %h", act, beat16(16'h0055)); end
        got++;
      end
    end
    n_cmp++; if (got != 1) begin n_err++; $display("FAIL flush_post_count got %0d want 1", got); end
    if_d2.valid_in = 1'b0;
    if_d2.ready_in = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if_d2.valid_in = 1'b1; drive_d2(c + 20);
    end
    @(posedge clk); #1;
    if_d2.valid_in = 1'b0;
    @(negedge clk);
    n_cmp++; if (if_d2.o_count !== 3'd4 || if_d2.ready_out !== 1'b0) begin
      n_err++; $display("FAIL rst_pre_full got cnt=%0d rdy=%b want cnt=4 rdy=0", if_d2.o_count, if_d2.ready_out); end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (if_d2.valid_out !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", if_d2.valid_out); end
    n_cmp++; if (if_d2.o_x !== 16'sd0) begin n_err++; $display("FAIL rst_ox got %h want 0", if_d2.o_x); end
    n_cmp++; if (if_d2.o_count !== 3'd0) begin n_err++; $display("FAIL rst_count got %0d want 0", if_d2.o_count); end
    n_cmp++; if (if_d2.ready_out !== 1'b1) begin n_err++; $display("FAIL rst_ready got %b want 1", if_d2.ready_out); end
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_random_stall();
    logic [97:0] q[$];
    logic [97:0] cur, act, held, exp;
    logic        held_vld = 1'b0;
    int          sent = 0;
    int          recv = 0;
    cur = {$urandom, $urandom, $urandom, 2'($urandom_range(0, 3))};
    for (int c = 0; c < 20000 && recv < 1000; c++) begin
      @(posedge clk); #1;
      if_d4.valid_in = (sent < 1000) && ($urandom_range(0, 1) == 1);
      {if_d4.i_x, if_d4.i_y, if_d4.i_z, if_d4.i_mode, if_d4.i_sign} = cur;
      if_d4.ready_in = (sent >= 1000) || ($urandom_range(0, 1) == 1);
      @(negedge clk);
      act = {if_d4.o_x, if_d4.o_y, if_d4.o_z, if_d4.o_mode, if_d4.o_sign};
      n_cmp++; if (int'(if_d4.o_count) != q.size() || if_d4.o_count > 4'd8) begin
        n_err++; $display("FAIL rnd_count c=%0d got %0d want %0d", c, if_d4.o_count, q.size()); end
      if (held_vld) begin
        n_cmp++; if (if_d4.valid_out !== 1'b1 || act !== held) begin
          n_err++; $display("FAIL rnd_stable c=%0d got %h want %h", c, act, held); end
      end
      if (if_d4.valid_out && if_d4.ready_in) begin
        n_cmp++;
        if (q.size() == 0) begin n_err++; $display("FAIL rnd_spurious c=%0d got %h want none", c, act); end
        else begin
          exp = q.pop_front();
          if (act !== exp) begin n_err++; $display("FAIL rnd_data #%0d got %h want %h", recv, act, exp); end
        end
        recv++;
      end
      held_vld = if_d4.valid_out && !if_d4.ready_in;
      held     = act;
      if (if_d4.valid_in && if_d4.ready_out) begin
        q.push_back(cur);
        sent++;
        cur = {$urandom, $urandom, $urandom, 2'($urandom_range(0, 3))};
      end
    end
    n_cmp++; if (recv != 1000) begin n_err++; $display("FAIL rnd_total got %0d want 1000", recv); end
    if_d4.valid_in = 1'b0;
    if_d4.ready_in = 1'b0;
  endtask

  task automatic test_signed_extremes();
    logic [97:0] exp [2];
    logic [97:0] act;
    int          got = 0;
    exp[0] = {32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0};
    exp[1] = {32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b1};
    if_d4.ready_in = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (c < 2) begin
        if_d4.valid_in = 1'b1;
        {if_d4.i_x, if_d4.i_y, if_d4.i_z, if_d4.i_mode, if_d4.i_sign} = exp[c];
      end else if_d4.valid_in = 1'b0;
      @(negedge clk);
      if (if_d4.valid_out === 1'b1) begin
        act = {if_d4.o_x, if_d4.o_y, if_d4.o_z, if_d4.o_mode, if_d4.o_sign};
        n_cmp++;
        if (got > 1) begin n_err++; $display("FAIL ext_extra got %h want none", act); end
        else if (act !== exp[got]) begin n_err++; $display("FAIL ext_data #%0d got %h want %h", got, act, exp[got]); end
        if (got == 0) begin
          n_cmp++; if (c != 4) begin n_err++; $display("FAIL ext_latency got %0d want 4", c); end
        end
        got++;
      end
    end
    n_cmp++; if (got != 2) begin n_err++; $display("FAIL ext_count got %0d want 2", got); end
    if_d4.ready_in = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random_stall();
    test_signed_extremes();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cordic_elastic_pipe.md
# cordic_elastic_pipe

A parametrised, back-pressurable pipeline for CORDIC iteration datapaths. It carries the x/y/z/mode/sign beat through DEPTH elastic stages under a valid/ready handshake, so one stalled stage no longer drops or duplicates beats. It also adds a synchronous flush and an occupancy count. It sits between CORDIC micro-rotation stages wherever the downstream consumer (output FIFO, bus interface) can stall.

## Interface
Parameters:
- WIDTH, 16, signed width of x, y and z
- DEPTH, 1, number of chained elastic stages (≥1)

Ports:
- clk  in  1  clock; all logic is on the rising edge
- rst_n  in  1  asynchronous active-low reset
- i_x, i_y, i_z  in  WIDTH  signed beat operands
- i_mode  in  1  rotation/vectoring mode bit travelling with the beat
- i_sign  in  1  quadrant/sign-correction bit travelling with the beat
- valid_in  in  1  upstream beat valid
- ready_out  out  1  this block can accept a beat; registered
- o_x, o_y, o_z  out  WIDTH  signed beat operands at the head of the pipe
- o_mode, o_sign  out  1  companion bits of the head beat
- valid_out  out  1  head beat valid; registered
- ready_in  in  1  downstream accepts the head beat
- flush  in  1  synchronous discard of all held beats
- o_count  out  $clog2(2*DEPTH+1)  number of beats currently held

## Operation
- Accept: valid_in & ready_out. Take: valid_out & ready_in. Payload is {x, y, z, mode, sign}, PW = 3*WIDTH+2 bits, and moves as one unit.
- Each stage is a skid stage with a main register, a skid register and a state in {EMPTY, HALF, FULL}.
  - Stage valid_out = (state != EMPTY).
  - Stage ready_out = (state != FULL). It is a register output, with no combinational path from ready_in.
- Stage transitions (acc = accepted, tk = taken):
  - EMPTY: acc → HALF, main ← in.
  - HALF, acc & !tk: → FULL, skid ← in.
  - HALF, !acc & tk: → EMPTY.
  - HALF, acc & tk: → HALF, main ← in.
  - HALF, neither: hold.
  - FULL, tk: → HALF, main ← skid. acc is impossible in FULL.
  - FULL, !tk: hold.
- Stage k's output feeds stage k+1's input. Stage DEPTH-1 drives the o_* outputs, valid_out and ready_in.
- o_count is the sum over stages of 0, 1 or 2 for EMPTY, HALF or FULL. It is updated in the same cycle as the states and is registered.
- flush has priority over every other event. On the next edge:
  - all stages go to EMPTY and o_count becomes 0;
  - a beat offered in the flush cycle is dropped;
  - data registers keep their values.
- Beats are never reordered, duplicated or dropped except by flush.

## Timing
- Reset (async assert, sync-released usage): all states EMPTY; valid_out=0; ready_out=1; o_count=0; o_x, o_y, o_z, o_mode and o_sign are 0.
- Latency with ready_in held at 1 is DEPTH cycles from accept to valid_out. Throughput is 1 beat/cycle. In this mode the block is cycle-equivalent to DEPTH plain registers.
- Capacity is 2*DEPTH beats. ready_out falls only when stage 0 is FULL.
- ready_in low for one cycle with a continuous stream:
  - no beat is lost;
  - the affected stage goes FULL;
  - it recovers one cycle after ready_in returns high.
- Payload outputs are stable while valid_out=1 & ready_in=0.
- rst_n asserted mid-stream clears everything immediately, with no final drain.
- flush and rst_n together: reset wins.

## Structure
- Shared package cordic_pipe_pkg holds:
  - typedef enum logic [1:0] {EMPTY, HALF, FULL} skid_state_t;
  - a function pipe_payload_w(width) returning 3*width+2.
- Sub-module cordic_skid_stage (parameter PW) contains:
  - one skid stage on a flat PW-bit payload;
  - ports clk, rst_n, flush, valid_in, ready_out, data_in, valid_out, ready_in, data_out, o_fill[1:0].
- Top level:
  - packs and unpacks the payload;
  - generates DEPTH instances;
  - sums o_fill into o_count.

## Test plan
- Streaming: DEPTH=3, WIDTH=16, ready_in=1, beats x=1..10 (y=-x, z=2x, mode and sign toggling). Required: outputs 1..10 in order, first valid_out 3 cycles after the first accept, valid_out continuous, ready_out always 1.
- Backpressure fill: DEPTH=2, ready_in=0, offer 6 beats. Required: ready_out drops after 4 accepts, o_count=4; then ready_in=1 drains beats 1..4 in order and then 5, 6.
- Random stall: DEPTH=4, 1000 random beats, random valid_in and ready_in at 50%. Required: the scoreboard sees the exact input sequence, o_count ≤ 8, and payload is stable during stalls.
- Flush: DEPTH=2, pipe holding 3 beats, assert flush together with valid_in on beat 0x7FFF. Required: next cycle valid_out=0, o_count=0, ready_out=1, and beat 0x7FFF is never output.
- Reset mid-operation: with the pipe FULL, pulse rst_n low between edges. Required: immediately valid_out=0, o_x=0, o_count=0, ready_out=1.
- Signed extremes: WIDTH=32, beat x=-2^31, y=2^31-1, z=-1. Required: bit-exact pass-through, including mode and sign.
